stage_if: RTL and testbench

STAGE_IF -- requirements
Module: stage_if

---
 rtl/stage_if_pkg.sv | 26 ++
 rtl/stage_if_if.sv | 25 ++
 rtl/stage_if_fetch_buf.sv | 78 +++++++
 rtl/stage_if.sv | 138 +++++++++++++
 tb/tb_stage_if.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the bus widths, reset polarity, IF state encoding and the buffer entry type.
package stage_if_pkg;

    localparam logic RST_ENABLE  = 1'b1;
    localparam int   INST_ADDR_W = 32;
    localparam int   INST_W      = 32;
    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        IF_IDLE    = 2'b00,
        IF_REQ     = 2'b01,
        IF_DISCARD = 2'b10
    } if_state_e;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/stage_if_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
// master = fetch stage, slave = instruction memory.
interface stage_if_if;
    import stage_if_pkg::*;

    logic                   mem_req_o;
    logic [INST_ADDR_W-1:0] mem_addr_o;
    logic                   mem_ack_i;
    logic [INST_W-1:0]      mem_data_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ack_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ack_i,
        output mem_data_i
    );

endinterface

// File: rtl/stage_if_fetch_buf.sv
// Small {pc, inst} FIFO sitting between the memory handshake and the decode register.
// DEPTH must be a power of two so the pointers wrap naturally.
module stage_if_fetch_buf
    import stage_if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              push,
    input  fetch_entry_t                      push_entry,
    input  logic                              pop,
    output fetch_entry_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic [$clog2(DEPTH+1)-1:0]        count_next
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;
    fetch_entry_t     entry_q [DEPTH];

    assign pop_ok  = pop && (count_reg != '0);
    assign push_ok = push && ((count_reg != FULL_CNT) || pop_ok);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;

            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_entry;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - CNT_W'(1);
        end
        if (clear) begin
            count_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    assign head  = entry_q[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/stage_if.sv
// Instruction fetch stage: single-outstanding memory fetcher feeding a small buffer,
// with a registered {pc, inst, valid} output toward decode. Flush overrides everything.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter int                     BUF_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [INST_ADDR_W-1:0] flush_pc_i,
    stage_if_if.master             mem,
    output logic [INST_ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0]      inst_o,
    output logic                   inst_valid_o
);

    localparam int CNT_W = $clog2(BUF_DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    if_state_e              state_reg, state_next;
    logic [INST_ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [INST_ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [INST_ADDR_W-1:0] pc_reg, pc_next;
    logic [INST_W-1:0]      inst_reg, inst_next;
    logic                   valid_reg, valid_next;

    logic                   push;
    logic                   pop;
    fetch_entry_t           push_entry;
    fetch_entry_t           head_entry;
    logic [CNT_W-1:0]       buf_count;
    logic [CNT_W-1:0]       buf_count_next;
    logic [INST_ADDR_W-1:0] pc_plus4;

    assign pc_plus4   = fetch_pc_reg + 32'd4;
    assign push       = !flush_i && (state_reg == IF_REQ) && mem.mem_ack_i;
    assign pop        = !flush_i && !stall_i && (buf_count != '0);
    assign push_entry = '{pc: mem_addr_reg, inst: mem.mem_data_i};

    stage_if_fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (flush_i),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head_entry),
        .count      (buf_count),
        .count_next (buf_count_next)
    );

    // Fetch FSM: the request address only moves on an ack, so the handshake stays stable.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        mem_addr_next = mem_addr_reg;
        unique case (state_reg)
            IF_IDLE: begin
                if (flush_i) begin
                    fetch_pc_next = word_align(flush_pc_i);
                end else if (buf_count < DEPTH_CNT) begin
                    state_next    = IF_REQ;
                    mem_addr_next = fetch_pc_reg;
                end
            end
            IF_REQ: begin
                if (flush_i) begin
                    fetch_pc_next = word_align(flush_pc_i);
                    state_next    = mem.mem_ack_i ? IF_IDLE : IF_DISCARD;
                end else if (mem.mem_ack_i) begin
                    fetch_pc_next = pc_plus4;
                    if (buf_count_next < DEPTH_CNT) begin
                        mem_addr_next = pc_plus4;
                    end else begin
                        state_next = IF_IDLE;
                    end
                end
            end
            IF_DISCARD: begin
                // Waiting out a request whose data belongs to the abandoned stream.
                if (flush_i) begin
                    fetch_pc_next = word_align(flush_pc_i);
                end
                if (mem.mem_ack_i) begin
                    state_next = IF_IDLE;
                end
            end
            default: begin
                state_next = IF_IDLE;
            end
        endcase
    end

    always_comb begin
        pc_next    = pc_reg;
        inst_next  = inst_reg;
        valid_next = valid_reg;
        if (flush_i || (!stall_i && (buf_count == '0))) begin
            pc_next    = ZERO_WORD;
            inst_next  = ZERO_WORD;
            valid_next = 1'b0;
        end else if (pop) begin
            pc_next    = head_entry.pc;
            inst_next  = head_entry.inst;
            valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_reg    <= IF_IDLE;
            fetch_pc_reg <= RESET_PC;
            mem_addr_reg <= ZERO_WORD;
            pc_reg       <= ZERO_WORD;
            inst_reg     <= ZERO_WORD;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            mem_addr_reg <= mem_addr_next;
            pc_reg       <= pc_next;
            inst_reg     <= inst_next;
            valid_reg    <= valid_next;
        end
    end

    assign mem.mem_req_o  = (state_reg != IF_IDLE);
    assign mem.mem_addr_o = mem_addr_reg;
    assign pc_o           = pc_reg;
    assign inst_o         = inst_reg;
    assign inst_valid_o   = valid_reg;

endmodule

// File: tb/tb_stage_if.sv
// Bench for stage_if: directed vector table, hand-written corner sequences and a
// randomized run checked by an in-order stream scoreboard.
module tb_stage_if;
    import stage_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic [31:0] pc, inst, pc_w, inst_w;
    logic        valid, valid_w;

    stage_if_if bus ();
    stage_if_if bus_w ();

    stage_if #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .flush_pc_i(flush_pc),
        .mem(bus.master), .pc_o(pc), .inst_o(inst), .inst_valid_o(valid)
    );

    stage_if #(.RESET_PC(32'hFFFF_FFFC), .BUF_DEPTH(2)) u_dut_wrap (
        .clk(clk), .rst(rst), .stall_i(1'b0), .flush_i(1'b0), .flush_pc_i(32'h0),
        .mem(bus_w.master), .pc_o(pc_w), .inst_o(inst_w), .inst_valid_o(valid_w)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: per-request latency drawn from [delay_min, delay_max].
    int   delay_min = 0, delay_max = 0;
    bit   force_ack = 1'b0;
    bit   pending = 1'b0;
    int   waited = 0, cur_delay = 0;
    always @(negedge clk) begin
        if (force_ack) begin
            bus.mem_ack_i  = 1'b1;
            bus.mem_data_i = 32'hBAD0_BAD0;
            pending        = 1'b0;
        end else if (!bus.mem_req_o) begin
            bus.mem_ack_i  = 1'b0;
            bus.mem_data_i = 32'h0;
            pending        = 1'b0;
        end else begin
            if (!pending || bus.mem_ack_i) begin
                pending   = 1'b1;
                waited    = 0;
                cur_delay = int'($urandom_range(delay_max, delay_min));
            end else begin
                waited++;
            end
            bus.mem_ack_i  = (waited >= cur_delay);
            bus.mem_data_i = bus.mem_ack_i ? memfn(bus.mem_addr_o) : 32'hDEAD_DEAD;
        end
    end

    always @(negedge clk) begin
        bus_w.mem_ack_i  = bus_w.mem_req_o;
        bus_w.mem_data_i = memfn(bus_w.mem_addr_o);
    end

    // Snapshot of the handshake as seen by the DUT at each rising edge.
    int          ack_events = 0;
    logic        e_req = 1'b0, e_ack = 1'b0;
    logic [31:0] e_addr = 32'h0;
    always @(posedge clk) begin
        e_req  = bus.mem_req_o;
        e_ack  = bus.mem_ack_i;
        e_addr = bus.mem_addr_o;
        if (!rst && e_req && e_ack) ack_events++;
    end

    int n_checks = 0, n_fail = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] fpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic f, input logic [31:0] fp,
                                input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.stall = s; v.flush = f; v.fpc = fp;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        logic [31:0] exp_pc, hp, hi, tgt;
        logic        hv, cur_flush, cur_stall;
        int          got, ev0, delivered;
        bit          found, acked;

        // Streaming from reset, a 2-cycle stall, then a redirect to 0x203.
        vecs[0]  = mk(0, 0, 32'h0,   1, 32'h000, 0, 32'h000);
        vecs[1]  = mk(0, 0, 32'h0,   1, 32'h004, 0, 32'h000);
        vecs[2]  = mk(0, 0, 32'h0,   1, 32'h008, 1, 32'h000);
        vecs[3]  = mk(0, 0, 32'h0,   1, 32'h00C, 1, 32'h004);
        vecs[4]  = mk(0, 0, 32'h0,   1, 32'h010, 1, 32'h008);
        vecs[5]  = mk(1, 0, 32'h0,   0, 32'h000, 1, 32'h008);
        vecs[6]  = mk(1, 0, 32'h0,   0, 32'h000, 1, 32'h008);
        vecs[7]  = mk(0, 0, 32'h0,   0, 32'h000, 1, 32'h00C);
        vecs[8]  = mk(0, 0, 32'h0,   1, 32'h014, 1, 32'h010);
        vecs[9]  = mk(0, 0, 32'h0,   1, 32'h018, 0, 32'h000);
        vecs[10] = mk(0, 0, 32'h0,   1, 32'h01C, 1, 32'h014);
        vecs[11] = mk(0, 1, 32'h203, 0, 32'h000, 0, 32'h000);
        vecs[12] = mk(0, 0, 32'h0,   1, 32'h200, 0, 32'h000);
        vecs[13] = mk(0, 0, 32'h0,   1, 32'h204, 0, 32'h000);
        vecs[14] = mk(0, 0, 32'h0,   1, 32'h208, 1, 32'h200);

        rst = 1'b1;
        repeat (3) tick();
        check("reset mem_req", bus.mem_req_o, 0);
        check("reset mem_addr", bus.mem_addr_o, 32'h0);
        check("reset pc", pc, 32'h0);
        check("reset inst", inst, 32'h0);
        check("reset valid", valid, 0);
        $display("reset: req=%b addr=%08h pc=%08h valid=%b", bus.mem_req_o, bus.mem_addr_o, pc, valid);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            stall = vecs[i].stall; flush = vecs[i].flush; flush_pc = vecs[i].fpc;
            tick();
            check($sformatf("vec%0d req", i), bus.mem_req_o, vecs[i].e_req);
            if (vecs[i].e_req) check($sformatf("vec%0d addr", i), bus.mem_addr_o, vecs[i].e_addr);
            check($sformatf("vec%0d valid", i), valid, vecs[i].e_valid);
            check($sformatf("vec%0d pc", i), pc, vecs[i].e_pc);
            check($sformatf("vec%0d inst", i), inst, vecs[i].e_valid ? memfn(vecs[i].e_pc) : 32'h0);
            if (i == 0) check("wrap first addr", bus_w.mem_addr_o, 32'hFFFF_FFFC);
            if (i == 1) check("wrap second addr", bus_w.mem_addr_o, 32'h0000_0000);
            if (i == 2) check("wrap first pc", pc_w, 32'hFFFF_FFFC);
            $display("vec %0d: req=%b addr=%08h valid=%b pc=%08h inst=%08h", i, bus.mem_req_o, bus.mem_addr_o, valid, pc, inst);
        end
        stall = 1'b0; flush = 1'b0;

        // Stall from an empty buffer: exactly BUF_DEPTH fetches, then the request drops.
        stall = 1'b1; flush = 1'b1; flush_pc = 32'h400;
        tick();
        flush = 1'b0;
        ev0 = ack_events;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("stall bubble held", valid, 0);
        end
        check("acks during stall", ack_events - ev0, 2);
        check("req after stall fill", bus.mem_req_o, 0);
        $display("stall: acks=%0d req=%b", ack_events - ev0, bus.mem_req_o);
        stall = 1'b0; exp_pc = 32'h400; got = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (valid) begin
                check("release pc sequence", pc, exp_pc);
                exp_pc += 4; got++;
            end
        end
        check("release delivered enough", got >= 6, 1);
        $display("release: %0d instructions, last pc=%08h", got, exp_pc - 4);

        // Flush while a slow request to 0x10 is outstanding.
        delay_min = 3; delay_max = 3;
        flush = 1'b1; flush_pc = 32'h10;
        tick();
        flush = 1'b0; found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (bus.mem_req_o && bus.mem_addr_o == 32'h10) found = 1;
        end
        check("request to 0x10 issued", found, 1);
        flush = 1'b1; flush_pc = 32'h103;
        tick();
        flush = 1'b0; acked = 0;
        for (int k = 0; k < 20 && !acked; k++) begin
            check("discard req held", bus.mem_req_o, 1);
            check("discard addr held", bus.mem_addr_o, 32'h10);
            tick();
            if (e_ack) acked = 1;
        end
        check("discard acked", acked, 1);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (bus.mem_req_o) found = 1;
        end
        check("request after discard seen", found, 1);
        check("redirect addr", bus.mem_addr_o, 32'h100);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (valid) found = 1; else tick();
        end
        check("redirect output seen", found, 1);
        check("redirect pc", pc, 32'h100);
        check("redirect inst", inst, memfn(32'h100));
        $display("discard: first pc after redirect=%08h", pc);

        // Flush together with stall and an ack: everything dropped.
        delay_min = 0; delay_max = 0;
        repeat (8) tick();
        stall = 1'b1; flush = 1'b1; flush_pc = 32'h800;
        ev0 = ack_events;
        tick();
        check("ack on flush edge", ack_events - ev0, 1);
        check("flush+stall valid", valid, 0);
        check("flush+stall pc", pc, 32'h0);
        check("flush+stall inst", inst, 32'h0);
        stall = 1'b0; flush = 1'b0;
        tick();
        check("buffer empty after flush", valid, 0);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (valid) found = 1;
        end
        check("post-flush output seen", found, 1);
        check("post-flush pc", pc, 32'h800);
        $display("flush+stall: first pc=%08h", pc);

        // Reset while a request is outstanding, then a stray ack during IDLE.
        delay_min = 3; delay_max = 3;
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (bus.mem_req_o) found = 1;
        end
        check("request before reset", found, 1);
        rst = 1'b1;
        tick();
        check("midreq reset req", bus.mem_req_o, 0);
        check("midreq reset addr", bus.mem_addr_o, 32'h0);
        check("midreq reset pc", pc, 32'h0);
        check("midreq reset inst", inst, 32'h0);
        check("midreq reset valid", valid, 0);
        rst = 1'b0; force_ack = 1'b1; delay_min = 0; delay_max = 0;
        tick();
        force_ack = 1'b0;
        check("post-reset req", bus.mem_req_o, 1);
        check("post-reset addr", bus.mem_addr_o, 32'h0);
        check("post-reset valid", valid, 0);
        found = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            if (valid) found = 1;
        end
        check("post-reset output seen", found, 1);
        check("post-reset pc", pc, 32'h0);
        check("post-reset inst", inst, memfn(32'h0));
        $display("reset mid-request: first pc=%08h inst=%08h", pc, inst);

        // Random traffic against an in-order stream scoreboard.
        delay_min = 0; delay_max = 3;
        exp_pc = 32'h4; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            stall    = ($urandom_range(99, 0) < 30);
            flush    = ($urandom_range(99, 0) < 3);
            flush_pc = $urandom;
            cur_flush = flush; cur_stall = stall; tgt = flush_pc;
            hp = pc; hi = inst; hv = valid;
            tick();
            if (cur_flush) begin
                check("rand flush valid", valid, 0);
                check("rand flush pc", pc, 32'h0);
                exp_pc = {tgt[31:2], 2'b00};
                $display("rand redirect at cycle %0d to %08h", c, exp_pc);
            end else if (cur_stall) begin
                check("rand stall pc", pc, hp);
                check("rand stall inst", inst, hi);
                check("rand stall valid", valid, hv);
            end else if (valid) begin
                check("rand stream pc", pc, exp_pc);
                check("rand stream inst", inst, memfn(exp_pc));
                exp_pc += 4; delivered++;
            end else begin
                check("rand bubble pc", pc, 32'h0);
                check("rand bubble inst", inst, 32'h0);
            end
            if (e_req && !e_ack) begin
                check("rand req held", bus.mem_req_o, 1);
                check("rand addr held", bus.mem_addr_o, e_addr);
            end
        end
        stall = 1'b0; flush = 1'b0;
        check("rand throughput", delivered >= 300, 1);
        $display("random: %0d instructions delivered", delivered);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
